// File: rtl/otter_cu_seq.sv
// Multi-cycle OTTER control unit: instruction register, FETCH/EXEC/WB/INTR
// sequencer, instruction decode and prioritised edge-latched interrupt logic.
module otter_cu_seq #(
   parameter int NUM_IRQ     = 4,
   parameter int MEM_WAIT_EN = 1,
   parameter int IRQ_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [31:0]        mem_rdata,
   input  logic               mem_ready,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               mie,
   input  logic               br_eq,
   input  logic               br_lt,
   input  logic               br_ltu,
   output logic               pc_write,
   output logic               rf_write,
   output logic               mem_rden1,
   output logic               mem_rden2,
   output logic               mem_we2,
   output logic               csr_we,
   output logic               int_taken,
   output logic [IRQ_W-1:0]   irq_id,
   output logic               illegal_op,
   output logic [3:0]         alu_func,
   output logic               alu_src_sel_a,
   output logic [1:0]         alu_src_sel_b,
   output logic [2:0]         pc_src_sel,
   output logic [1:0]         rfile_w_sel
);

   localparam logic [1:0] FETCH = 2'd0;
   localparam logic [1:0] EXEC  = 2'd1;
   localparam logic [1:0] WB    = 2'd2;
   localparam logic [1:0] INTR  = 2'd3;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   logic [1:0]         state;
   logic [1:0]         next_state;
   logic [31:0]        ir;
   logic [NUM_IRQ-1:0] pending;
   logic [NUM_IRQ-1:0] irq_q;
   logic [NUM_IRQ-1:0] pend_clr;
   logic [NUM_IRQ-1:0] sel_onehot;
   logic [IRQ_W-1:0]   irq_sel;
   logic               ready;
   logic               cmp;
   logic [6:0]         opcode;
   logic [2:0]         f3;
   logic               unused_ir;

   assign ready     = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
   assign opcode    = ir[6:0];
   assign f3        = ir[14:12];
   assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= FETCH;
         ir      <= '0;
         pending <= '0;
         irq_q   <= '0;
      end else begin
         state <= next_state;
         irq_q <= irq;
         // new edges are OR'd in after the clear so a same-cycle edge survives
         pending <= (pending & ~pend_clr) | (irq & ~irq_q);
         if (state == FETCH && ready)
            ir <= mem_rdata;
      end
   end

   // lowest index wins: scan downward so the last hit is the smallest index
   always_comb begin
      irq_sel    = '0;
      sel_onehot = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (pending[i]) begin
            irq_sel       = IRQ_W'(i);
            sel_onehot    = '0;
            sel_onehot[i] = 1'b1;
         end
      end
   end

   always_comb begin
      cmp = 1'b0;
      case (f3[2:1])
         2'd0:    cmp = br_eq;
         2'd2:    cmp = br_lt;
         2'd3:    cmp = br_ltu;
         default: cmp = 1'b0;
      endcase
   end

   always_comb begin
      next_state    = state;
      pend_clr      = '0;
      pc_write      = 1'b0;
      rf_write      = 1'b0;
      mem_rden1     = 1'b0;
      mem_rden2     = 1'b0;
      mem_we2       = 1'b0;
      csr_we        = 1'b0;
      int_taken     = 1'b0;
      irq_id        = '0;
      illegal_op    = 1'b0;
      alu_func      = 4'd0;
      alu_src_sel_a = 1'b0;
      alu_src_sel_b = 2'd0;
      pc_src_sel    = 3'd0;
      rfile_w_sel   = 2'd0;
      case (state)
         FETCH: begin
            mem_rden1 = 1'b1;
            if (ready)
               next_state = EXEC;
         end
         EXEC: begin
            case (opcode)
               OP_R: begin
                  alu_func    = {ir[30], f3};
                  rfile_w_sel = 2'd3;
                  rf_write    = 1'b1;
                  pc_write    = 1'b1;
               end
               OP_IMM: begin
                  alu_func      = {(f3 == 3'b101) ? ir[30] : 1'b0, f3};
                  alu_src_sel_b = 2'd1;
                  rfile_w_sel   = 2'd3;
                  rf_write      = 1'b1;
                  pc_write      = 1'b1;
               end
               OP_LUI: begin
                  alu_src_sel_a = 1'b1;
                  alu_func      = 4'd9;
                  rfile_w_sel   = 2'd3;
                  rf_write      = 1'b1;
                  pc_write      = 1'b1;
               end
               OP_AUIPC: begin
                  alu_src_sel_a = 1'b1;
                  alu_src_sel_b = 2'd3;
                  rfile_w_sel   = 2'd3;
                  rf_write      = 1'b1;
                  pc_write      = 1'b1;
               end
               OP_JAL: begin
                  pc_src_sel = 3'd3;
                  rf_write   = 1'b1;
                  pc_write   = 1'b1;
               end
               OP_JALR: begin
                  pc_src_sel = 3'd1;
                  rf_write   = 1'b1;
                  pc_write   = 1'b1;
               end
               OP_BRANCH: begin
                  pc_src_sel = (cmp != f3[0]) ? 3'd2 : 3'd0;
                  pc_write   = 1'b1;
               end
               OP_SYSTEM: begin
                  if (f3[0]) begin
                     csr_we      = 1'b1;
                     rf_write    = 1'b1;
                     rfile_w_sel = 2'd1;
                  end else begin
                     pc_src_sel = 3'd5;
                  end
                  pc_write = 1'b1;
               end
               OP_STORE: begin
                  alu_src_sel_b = 2'd2;
                  mem_we2       = 1'b1;
                  pc_write      = ready;
               end
               OP_LOAD: begin
                  alu_src_sel_b = 2'd1;
                  mem_rden2     = 1'b1;
                  if (ready)
                     next_state = WB;
               end
               default: begin
                  illegal_op = 1'b1;
                  pc_write   = 1'b1;
               end
            endcase
         end
         WB: begin
            rfile_w_sel = 2'd2;
            rf_write    = ready;
            pc_write    = ready;
         end
         default: begin
            int_taken  = 1'b1;
            pc_write   = 1'b1;
            pc_src_sel = 3'd4;
            irq_id     = irq_sel;
            pend_clr   = sel_onehot;
            next_state = FETCH;
         end
      endcase
      // interrupts are only considered once the current instruction retires
      if ((state == EXEC || state == WB) && pc_write)
         next_state = (mie && (|pending)) ? INTR : FETCH;
   end

endmodule

// File: tb/tb_otter_cu_seq.sv
// Scoreboard bench for otter_cu_seq: each step pushes its expected output
// vector, which is popped and compared at the following falling edge.
module tb_otter_cu_seq;

   logic        clk;
   logic        rst_n;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic [3:0]  irq;
   logic        mie;
   logic        br_eq;
   logic        br_lt;
   logic        br_ltu;
   logic        pc_write;
   logic        rf_write;
   logic        mem_rden1;
   logic        mem_rden2;
   logic        mem_we2;
   logic        csr_we;
   logic        int_taken;
   logic [1:0]  irq_id;
   logic        illegal_op;
   logic [3:0]  alu_func;
   logic        alu_src_sel_a;
   logic [1:0]  alu_src_sel_b;
   logic [2:0]  pc_src_sel;
   logic [1:0]  rfile_w_sel;
   logic [21:0] act;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic [31:0] rdata;
      logic        ready;
      logic [3:0]  irq;
      logic        mie;
      logic [2:0]  br;
      logic [21:0] exp;
   } step_t;

   step_t sb[$];

   localparam logic [31:0] I_ADDI  = 32'h00500093;
   localparam logic [31:0] I_ADDI30 = 32'h40000093;
   localparam logic [31:0] I_SRAI  = 32'h4010D093;
   localparam logic [31:0] I_SUB   = 32'h402081B3;
   localparam logic [31:0] I_LUI   = 32'h123450B7;
   localparam logic [31:0] I_AUIPC = 32'h00001097;
   localparam logic [31:0] I_JAL   = 32'h008000EF;
   localparam logic [31:0] I_JALR  = 32'h000080E7;
   localparam logic [31:0] I_CSRRW = 32'h30529073;
   localparam logic [31:0] I_MRET  = 32'h30200073;
   localparam logic [31:0] I_LW    = 32'h0000A103;
   localparam logic [31:0] I_SW    = 32'h0020A023;
   localparam logic [31:0] I_BNE   = 32'h00209463;
   localparam logic [31:0] I_BGE   = 32'h0020D463;
   localparam logic [31:0] I_BLTU  = 32'h0020E463;
   localparam logic [31:0] I_ILL   = 32'h0000007F;

   otter_cu_seq #(.NUM_IRQ(4), .MEM_WAIT_EN(1)) dut (
      .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .irq(irq), .mie(mie), .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu),
      .pc_write(pc_write), .rf_write(rf_write), .mem_rden1(mem_rden1),
      .mem_rden2(mem_rden2), .mem_we2(mem_we2), .csr_we(csr_we),
      .int_taken(int_taken), .irq_id(irq_id), .illegal_op(illegal_op),
      .alu_func(alu_func), .alu_src_sel_a(alu_src_sel_a),
      .alu_src_sel_b(alu_src_sel_b), .pc_src_sel(pc_src_sel),
      .rfile_w_sel(rfile_w_sel)
   );

   assign act = {pc_write, rf_write, mem_rden1, mem_rden2, mem_we2, csr_we, int_taken,
                 irq_id, illegal_op, alu_func, alu_src_sel_a, alu_src_sel_b,
                 pc_src_sel, rfile_w_sel};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Field order: pcw rfw rden1 rden2 we2 csr int id ill alu srcA srcB pcsel wsel
   function automatic logic [21:0] ov(int pcw, int rfw, int rd1, int rd2, int we2, int csr,
                                      int it, int id, int ill, int af, int sa, int sbs,
                                      int pcs, int rws);
      return {1'(pcw), 1'(rfw), 1'(rd1), 1'(rd2), 1'(we2), 1'(csr), 1'(it), 2'(id),
              1'(ill), 4'(af), 1'(sa), 2'(sbs), 3'(pcs), 2'(rws)};
   endfunction

   function automatic step_t st(string n, logic [31:0] rd, logic rdy, logic [3:0] iq,
                                logic m, logic [2:0] br, logic [21:0] e);
      step_t s;
      s.name = n; s.rdata = rd; s.ready = rdy; s.irq = iq; s.mie = m; s.br = br; s.exp = e;
      return s;
   endfunction

   function automatic logic [21:0] fetch_out();
      return ov(0,0,1,0,0,0,0,0,0,0,0,0,0,0);
   endfunction

   function automatic logic [21:0] addi_out();
      return ov(1,1,0,0,0,0,0,0,0,0,0,1,0,3);
   endfunction

   function automatic logic [21:0] intr_out(int id);
      return ov(1,0,0,0,0,0,1,id,0,0,0,0,4,0);
   endfunction

   // Drives one cycle of inputs, records the expectation, waits to the falling edge
   task automatic drive_step(input step_t s);
      mem_rdata = s.rdata;
      mem_ready = s.ready;
      irq       = s.irq;
      mie       = s.mie;
      {br_ltu, br_lt, br_eq} = s.br;
      sb.push_back(s);
      @(negedge clk);
   endtask

   task automatic test_reset();
      step_t s;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      drive_step(st("reset_outputs", 32'h0, 1'b1, 4'h0, 1'b0, 3'b000, fetch_out()));
      s = sb.pop_front();
      checks++;
      if (act !== s.exp) begin
         failures++;
         $display("[TB] FAIL %s got=%h exp=%h", s.name, act, s.exp);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_addi();
      step_t q[$];
      q.push_back(st("addi_fetch", I_ADDI, 1'b1, 4'h0, 1'b0, 3'b000, fetch_out()));
      q.push_back(st("addi_exec",  I_ADDI, 1'b1, 4'h0, 1'b0, 3'b000, addi_out()));
      q.push_back(st("addi_refetch", 32'h0, 1'b0, 4'h0, 1'b0, 3'b000, fetch_out()));
      q.push_back(st("fetch_hold", 32'h0, 1'b0, 4'h0, 1'b0, 3'b000, fetch_out()));
      foreach (q[k]) begin
         step_t s;
         drive_step(q[k]);
         s = sb.pop_front();
         checks++;
         if (act !== s.exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", s.name, act, s.exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_decode();
      step_t q[$];
      logic [31:0] ins[10] = '{I_SUB, I_SRAI, I_ADDI30, I_LUI, I_AUIPC, I_JAL, I_JALR,
                               I_CSRRW, I_MRET, I_ILL};
      logic [21:0] exps[10];
      string names[10] = '{"sub", "srai", "addi_bit30", "lui", "auipc", "jal", "jalr",
                           "csrrw", "mret", "illegal"};
      exps[0] = ov(1,1,0,0,0,0,0,0,0,8,0,0,0,3);
      exps[1] = ov(1,1,0,0,0,0,0,0,0,13,0,1,0,3);
      exps[2] = ov(1,1,0,0,0,0,0,0,0,0,0,1,0,3);
      exps[3] = ov(1,1,0,0,0,0,0,0,0,9,1,0,0,3);
      exps[4] = ov(1,1,0,0,0,0,0,0,0,0,1,3,0,3);
      exps[5] = ov(1,1,0,0,0,0,0,0,0,0,0,0,3,0);
      exps[6] = ov(1,1,0,0,0,0,0,0,0,0,0,0,1,0);
      exps[7] = ov(1,1,0,0,0,1,0,0,0,0,0,0,0,1);
      exps[8] = ov(1,0,0,0,0,0,0,0,0,0,0,0,5,0);
      exps[9] = ov(1,0,0,0,0,0,0,0,1,0,0,0,0,0);
      for (int i = 0; i < 10; i++) begin
         q.push_back(st({names[i], "_fetch"}, ins[i], 1'b1, 4'h0, 1'b0, 3'b000, fetch_out()));
         q.push_back(st(names[i], ins[i], 1'b1, 4'h0, 1'b0, 3'b000, exps[i]));
      end
      q.push_back(st("decode_end", 32'h0, 1'b0, 4'h0, 1'b0, 3'b000, fetch_out()));
      foreach (q[k]) begin
         step_t s;
         drive_step(q[k]);
         s = sb.pop_front();
         checks++;
         if (act !== s.exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", s.name, act, s.exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch();
      step_t q[$];
      logic [21:0] tk = ov(1,0,0,0,0,0,0,0,0,0,0,0,2,0);
      logic [21:0] nt = ov(1,0,0,0,0,0,0,0,0,0,0,0,0,0);
      q.push_back(st("bne_f", I_BNE, 1'b1, 4'h0, 1'b0, 3'b000, fetch_out()));
      q.push_back(st("bne_taken", I_BNE, 1'b1, 4'h0, 1'b0, 3'b000, tk));
      q.push_back(st("bne2_f", I_BNE, 1'b1, 4'h0, 1'b0, 3'b001, fetch_out()));
      q.push_back(st("bne_not_taken", I_BNE, 1'b1, 4'h0, 1'b0, 3'b001, nt));
      q.push_back(st("bltu_f", I_BLTU, 1'b1, 4'h0, 1'b0, 3'b100, fetch_out()));
      q.push_back(st("bltu_taken", I_BLTU, 1'b1, 4'h0, 1'b0, 3'b100, tk));
      q.push_back(st("bge_f", I_BGE, 1'b1, 4'h0, 1'b0, 3'b010, fetch_out()));
      q.push_back(st("bge_not_taken", I_BGE, 1'b1, 4'h0, 1'b0, 3'b010, nt));
      q.push_back(st("branch_end", 32'h0, 1'b0, 4'h0, 1'b0, 3'b000, fetch_out()));
      foreach (q[k]) begin
         step_t s;
         drive_step(q[k]);
         s = sb.pop_front();
         checks++;
         if (act !== s.exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", s.name, act, s.exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_wait();
      step_t q[$];
      logic [21:0] wb_wait = ov(0,0,0,0,0,0,0,0,0,0,0,0,0,2);
      logic [21:0] ld_exec = ov(0,0,0,1,0,0,0,0,0,0,0,1,0,0);
      q.push_back(st("lw_fetch", I_LW, 1'b1, 4'h0, 1'b0, 3'b000, fetch_out()));
      q.push_back(st("lw_exec_wait", I_LW, 1'b0, 4'h0, 1'b0, 3'b000, ld_exec));
      q.push_back(st("lw_exec", I_LW, 1'b1, 4'h0, 1'b0, 3'b000, ld_exec));
      for (int i = 0; i < 3; i++)
         q.push_back(st("lw_wb_hold", I_LW, 1'b0, 4'h0, 1'b0, 3'b000, wb_wait));
      q.push_back(st("lw_wb_done", I_LW, 1'b1, 4'h0, 1'b0, 3'b000, ov(1,1,0,0,0,0,0,0,0,0,0,0,0,2)));
      q.push_back(st("lw_end", 32'h0, 1'b0, 4'h0, 1'b0, 3'b000, fetch_out()));
      foreach (q[k]) begin
         step_t s;
         drive_step(q[k]);
         s = sb.pop_front();
         checks++;
         if (act !== s.exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", s.name, act, s.exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_irq_priority();
      step_t q[$];
      logic [21:0] sw_wait = ov(0,0,0,0,1,0,0,0,0,0,0,2,0,0);
      q.push_back(st("sw_fetch", I_SW, 1'b1, 4'h0, 1'b1, 3'b000, fetch_out()));
      q.push_back(st("sw_wait_irq", I_SW, 1'b0, 4'b0110, 1'b1, 3'b000, sw_wait));
      q.push_back(st("sw_wait", I_SW, 1'b0, 4'h0, 1'b1, 3'b000, sw_wait));
      q.push_back(st("sw_done", I_SW, 1'b1, 4'h0, 1'b1, 3'b000, ov(1,0,0,0,1,0,0,0,0,0,0,2,0,0)));
      q.push_back(st("intr_id1", I_SW, 1'b1, 4'h0, 1'b1, 3'b000, intr_out(1)));
      q.push_back(st("between_fetch", I_ADDI, 1'b1, 4'h0, 1'b1, 3'b000, fetch_out()));
      q.push_back(st("between_exec", I_ADDI, 1'b1, 4'h0, 1'b1, 3'b000, addi_out()));
      q.push_back(st("intr_id2", I_ADDI, 1'b1, 4'h0, 1'b1, 3'b000, intr_out(2)));
      q.push_back(st("irq_end", 32'h0, 1'b0, 4'h0, 1'b1, 3'b000, fetch_out()));
      foreach (q[k]) begin
         step_t s;
         drive_step(q[k]);
         s = sb.pop_front();
         checks++;
         if (act !== s.exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", s.name, act, s.exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_irq_mask();
      step_t q[$];
      q.push_back(st("mask_fetch", I_ADDI, 1'b1, 4'b0001, 1'b0, 3'b000, fetch_out()));
      q.push_back(st("masked_exec", I_ADDI, 1'b1, 4'b0001, 1'b0, 3'b000, addi_out()));
      q.push_back(st("no_intr_when_masked", I_ADDI, 1'b1, 4'b0001, 1'b1, 3'b000, fetch_out()));
      q.push_back(st("unmasked_exec", I_ADDI, 1'b1, 4'b0001, 1'b1, 3'b000, addi_out()));
      q.push_back(st("intr_id0", I_ADDI, 1'b1, 4'b0001, 1'b1, 3'b000, intr_out(0)));
      q.push_back(st("level_fetch", I_ADDI, 1'b1, 4'b0001, 1'b1, 3'b000, fetch_out()));
      q.push_back(st("level_exec", I_ADDI, 1'b1, 4'b0001, 1'b1, 3'b000, addi_out()));
      q.push_back(st("level_no_reentry", 32'h0, 1'b0, 4'b0001, 1'b1, 3'b000, fetch_out()));
      foreach (q[k]) begin
         step_t s;
         drive_step(q[k]);
         s = sb.pop_front();
         checks++;
         if (act !== s.exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", s.name, act, s.exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_wb();
      step_t q[$];
      step_t s;
      q.push_back(st("rst_lw_fetch", I_LW, 1'b1, 4'b1000, 1'b1, 3'b000, fetch_out()));
      q.push_back(st("rst_lw_exec", I_LW, 1'b1, 4'h0, 1'b1, 3'b000, ov(0,0,0,1,0,0,0,0,0,0,0,1,0,0)));
      q.push_back(st("rst_lw_wb", I_LW, 1'b0, 4'h0, 1'b1, 3'b000, ov(0,0,0,0,0,0,0,0,0,0,0,0,0,2)));
      foreach (q[k]) begin
         drive_step(q[k]);
         s = sb.pop_front();
         checks++;
         if (act !== s.exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", s.name, act, s.exp);
         end
         @(posedge clk); #1;
      end
      // asynchronous: outputs must drop with no clock edge in between
      rst_n = 1'b0;
      sb.push_back(st("async_reset_wb", I_LW, 1'b0, 4'h0, 1'b1, 3'b000, fetch_out()));
      #1;
      s = sb.pop_front();
      checks++;
      if (act !== s.exp) begin
         failures++;
         $display("[TB] FAIL %s got=%h exp=%h", s.name, act, s.exp);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      q.delete();
      q.push_back(st("post_rst_fetch", I_ADDI, 1'b1, 4'h0, 1'b1, 3'b000, fetch_out()));
      q.push_back(st("post_rst_exec", I_ADDI, 1'b1, 4'h0, 1'b1, 3'b000, addi_out()));
      q.push_back(st("pending_cleared", 32'h0, 1'b0, 4'h0, 1'b1, 3'b000, fetch_out()));
      foreach (q[k]) begin
         drive_step(q[k]);
         s = sb.pop_front();
         checks++;
         if (act !== s.exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", s.name, act, s.exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_irq_high_at_reset();
      step_t q[$];
      rst_n = 1'b0;
      irq   = 4'b1000;
      @(posedge clk); #1;
      rst_n = 1'b1;
      q.push_back(st("hi_rst_fetch", I_ADDI, 1'b1, 4'b1000, 1'b1, 3'b000, fetch_out()));
      q.push_back(st("hi_rst_exec", I_ADDI, 1'b1, 4'b1000, 1'b1, 3'b000, addi_out()));
      q.push_back(st("intr_id3", I_ADDI, 1'b1, 4'b1000, 1'b1, 3'b000, intr_out(3)));
      q.push_back(st("hi_rst_end", 32'h0, 1'b0, 4'h0, 1'b1, 3'b000, fetch_out()));
      foreach (q[k]) begin
         step_t s;
         drive_step(q[k]);
         s = sb.pop_front();
         checks++;
         if (act !== s.exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", s.name, act, s.exp);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      mem_rdata = 32'h0;
      mem_ready = 1'b0;
      irq       = 4'h0;
      mie       = 1'b0;
      br_eq     = 1'b0;
      br_lt     = 1'b0;
      br_ltu    = 1'b0;
      test_reset();
      test_addi();
      test_load_wait();
      test_branch();
      test_decode();
      test_irq_priority();
      test_irq_mask();
      test_reset_mid_wb();
      test_irq_high_at_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
